// File: rtl/decode_pipe_stage_if.sv
// Decoded-instruction bus between pipeline stages: valid/ready handshake plus operand payload.
interface decode_pipe_stage_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 16
);
    logic                  valid;
    logic                  ready;
    logic [XLEN-1:0]       pc;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       imm;
    logic [CTRL_W-1:0]     ctrl;
    logic                  rd_we;

    modport master (
        output valid, pc, rs1_addr, rs2_addr, rd_addr, rs1_data, rs2_data, imm, ctrl, rd_we,
        input  ready
    );

    modport slave (
        input  valid, pc, rs1_addr, rs2_addr, rd_addr, rs1_data, rs2_data, imm, ctrl, rd_we,
        output ready
    );
endinterface

// File: rtl/decode_pipe_stage.sv
// Decode->execute register slice with skid entry and writeback forwarding; 1-cycle latency.
// Backpressure: registered in_bus.ready drops only once the skid entry is occupied.
module decode_pipe_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 16,
    parameter int FWD_EN     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    decode_pipe_stage_if.slave    in_bus,
    decode_pipe_stage_if.master   out_bus,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  flush,
    output logic [XLEN-1:0]       store_data,
    output logic [1:0]            occupancy
);

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [REG_ADDR_W-1:0] rs1_addr;
        logic [REG_ADDR_W-1:0] rs2_addr;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [XLEN-1:0]       rs1_data;
        logic [XLEN-1:0]       rs2_data;
        logic [XLEN-1:0]       imm;
        logic [CTRL_W-1:0]     ctrl;
        logic                  rd_we;
    } entry_t;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    logic   in_ready_q;
    logic   out_valid_q;
    entry_t main_q;
    entry_t skid_q;
    entry_t in_entry;
    logic   in_hs;
    logic   out_hs;

    function automatic logic fwd_hit(input logic [REG_ADDR_W-1:0] a);
        return (FWD_EN != 0) && wb_we && (wb_addr == a) && (wb_addr != '0);
    endfunction

    function automatic entry_t fwd(input entry_t e);
        entry_t r;
        r = e;
        if (fwd_hit(e.rs1_addr)) r.rs1_data = wb_data;
        if (fwd_hit(e.rs2_addr)) r.rs2_data = wb_data;
        return r;
    endfunction

    always_comb begin
        in_entry          = '0;
        in_entry.pc       = in_bus.pc;
        in_entry.rs1_addr = in_bus.rs1_addr;
        in_entry.rs2_addr = in_bus.rs2_addr;
        in_entry.rd_addr  = in_bus.rd_addr;
        in_entry.rs1_data = in_bus.rs1_data;
        in_entry.rs2_data = in_bus.rs2_data;
        in_entry.imm      = in_bus.imm;
        in_entry.ctrl     = in_bus.ctrl;
        in_entry.rd_we    = in_bus.rd_we;
    end

    assign in_hs  = in_bus.valid & in_ready_q;
    assign out_hs = out_valid_q & out_bus.ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_q      <= '0;
            skid_q      <= '0;
        end else begin
            // Held entries keep absorbing writebacks every cycle they stay resident.
            if (state == FULL) begin
                if (out_hs) begin
                    main_q <= fwd(skid_q);
                end else begin
                    main_q <= fwd(main_q);
                    skid_q <= fwd(skid_q);
                end
            end else if (state == ONE && !out_hs) begin
                main_q <= fwd(main_q);
                if (in_hs) skid_q <= fwd(in_entry);
            end else if (in_hs) begin
                main_q <= fwd(in_entry);
            end

            if (flush) begin
                state       <= EMPTY;
                in_ready_q  <= 1'b1;
                out_valid_q <= 1'b0;
            end else begin
                case (state)
                    EMPTY: if (in_hs) begin
                        state       <= ONE;
                        out_valid_q <= 1'b1;
                    end
                    ONE: begin
                        if (in_hs && !out_hs) begin
                            state      <= FULL;
                            in_ready_q <= 1'b0;
                        end else if (!in_hs && out_hs) begin
                            state       <= EMPTY;
                            out_valid_q <= 1'b0;
                        end
                    end
                    FULL: if (out_hs) begin
                        state      <= ONE;
                        in_ready_q <= 1'b1;
                    end
                    default: begin
                        state       <= EMPTY;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign in_bus.ready     = in_ready_q;
    assign out_bus.valid    = out_valid_q;
    assign out_bus.pc       = main_q.pc;
    assign out_bus.rs1_addr = main_q.rs1_addr;
    assign out_bus.rs2_addr = main_q.rs2_addr;
    assign out_bus.rd_addr  = main_q.rd_addr;
    assign out_bus.rs1_data = main_q.rs1_data;
    assign out_bus.rs2_data = main_q.rs2_data;
    assign out_bus.imm      = main_q.imm;
    assign out_bus.ctrl     = main_q.ctrl;
    assign out_bus.rd_we    = main_q.rd_we & out_valid_q;
    assign store_data       = main_q.rs2_data;
    assign occupancy        = state;

endmodule
